// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcodes, opcode field position,
// FSM states and fault codes used by the fetch unit, ROM and decoder.
package fetch_unit_pkg;

    localparam int OPC_MSB = 27;
    localparam int OPC_LSB = 24;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_OVERFLOW  = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Hardware return-address LIFO for CALL/RET.
// Pointer counts live entries: 0 = empty, STACK_DEPTH = full.
module return_stack #(
    parameter int STACK_DEPTH = 8,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  full,
    output logic                  empty
);

    localparam int IW = $clog2(STACK_DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_d [STACK_DEPTH];
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         top_idx;

    assign full    = (ptr_q == PW'(STACK_DEPTH));
    assign empty   = (ptr_q == '0);
    assign wr_idx  = ptr_q[IW-1:0];
    assign top_idx = IW'(ptr_q - PW'(1));
    assign top     = mem_q[top_idx];

    // Next pointer and storage; misuse (push full / pop empty) is ignored.
    always_comb begin
        ptr_d = ptr_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[wr_idx] = data_in;
            ptr_d         = ptr_q + PW'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    // Stack registers, cleared on reset so no stale entry survives.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ptr_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC / instruction fetch stage ahead of a combinational ROM.
// Resolves CALL/RET locally, takes branch redirects, faults on stack misuse.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSN_WIDTH  = 28,
    parameter int STACK_DEPTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iEnable,
    input  logic [INSN_WIDTH-1:0] iInstruction,
    input  logic                  iBranchTaken,
    input  logic [ADDR_WIDTH-1:0] iBranchTarget,
    output logic [ADDR_WIDTH-1:0] oAddress,
    output logic [INSN_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    output logic                  oFault,
    output logic [1:0]            oFaultCode
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INSN_WIDTH-1:0] insn_q, insn_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic [1:0]            code_q, code_d;

    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] stk_top;
    logic                  stk_full, stk_empty;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] call_tgt;
    logic                  is_call, is_ret;

    assign pc_inc   = pc_q + ADDR_WIDTH'(1);
    assign call_tgt = ADDR_WIDTH'(iInstruction[23:16]);
    assign is_call  = (iInstruction[OPC_MSB:OPC_LSB] == OP_CALL);
    assign is_ret   = (iInstruction[OPC_MSB:OPC_LSB] == OP_RET);

    return_stack #(
        .STACK_DEPTH(STACK_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_stack (
        .Clock  (Clock),
        .Reset  (Reset),
        .push   (push),
        .pop    (pop),
        .data_in(pc_inc),
        .top    (stk_top),
        .full   (stk_full),
        .empty  (stk_empty)
    );

    // Next-state: boot bubble, prioritised run actions, absorbing fault.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        valid_d = valid_q;
        fault_d = fault_q;
        code_d  = code_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                valid_d = 1'b0;
            end
            S_RUN: begin
                if (iEnable) begin
                    if (iBranchTaken) begin
                        pc_d    = iBranchTarget;
                        valid_d = 1'b0;
                    end else if (is_call && stk_full) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        code_d  = FC_OVERFLOW;
                        valid_d = 1'b0;
                    end else if (is_call) begin
                        push    = 1'b1;
                        pc_d    = call_tgt;
                        insn_d  = iInstruction;
                        valid_d = 1'b1;
                    end else if (is_ret && stk_empty) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        code_d  = FC_UNDERFLOW;
                        valid_d = 1'b0;
                    end else if (is_ret) begin
                        pop     = 1'b1;
                        pc_d    = stk_top;
                        insn_d  = iInstruction;
                        valid_d = 1'b1;
                    end else begin
                        pc_d    = pc_inc;
                        insn_d  = iInstruction;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_FAULT;
                fault_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    // Stage registers; every output comes straight from a flop.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_BOOT;
            pc_q    <= '0;
            insn_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign oAddress     = pc_q;
    assign oInstruction = insn_q;
    assign oValid       = valid_q;
    assign oFault       = fault_q;
    assign oFaultCode   = code_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// programs compared against a queue-based reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        br;
    logic [15:0] tgt;
    logic [27:0] insn_in;
    logic [15:0] o_addr;
    logic [27:0] o_insn;
    logic        o_valid;
    logic        o_fault;
    logic [1:0]  o_code;

    logic [27:0] rom [0:65535];

    int errors = 0;
    int checks = 0;

    int          m_pc;
    int          m_stack[$];
    bit          m_boot;
    bit          m_fault;
    bit          m_valid;
    logic [1:0]  m_code;
    logic [27:0] m_insn;
    logic [47:0] got;
    logic [47:0] exp;

    fetch_unit dut (
        .Clock        (clk),
        .Reset        (rst),
        .iEnable      (en),
        .iInstruction (insn_in),
        .iBranchTaken (br),
        .iBranchTarget(tgt),
        .oAddress     (o_addr),
        .oInstruction (o_insn),
        .oValid       (o_valid),
        .oFault       (o_fault),
        .oFaultCode   (o_code)
    );

    assign insn_in = rom[o_addr];

    always #5 clk = ~clk;

    task automatic rom_clear(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) rom[i] = {OP_NOP, 24'(i)};
    endtask

    task automatic model_reset;
        m_pc = 0;
        m_stack.delete();
        m_boot = 1;
        m_fault = 0;
        m_valid = 0;
        m_code = 2'b00;
        m_insn = '0;
    endtask

    task automatic snap;
        got = {o_addr, o_valid, o_insn, o_fault, o_code};
        exp = {16'(m_pc), m_valid, m_insn, m_fault, m_code};
    endtask

    // Advance the model by the specified rules, then clock the DUT.
    task automatic tick;
        logic [27:0] w;
        w = rom[m_pc];
        if (m_fault) begin
        end else if (m_boot) begin
            m_boot = 0;
            m_valid = 0;
        end else if (en) begin
            if (br) begin
                m_pc = tgt;
                m_valid = 0;
            end else if (w[27:24] == OP_CALL) begin
                if (m_stack.size() == 8) begin
                    m_fault = 1; m_code = 2'b01; m_valid = 0;
                end else begin
                    m_stack.push_back((m_pc + 1) % 65536);
                    m_pc = w[23:16];
                    m_insn = w; m_valid = 1;
                end
            end else if (w[27:24] == OP_RET) begin
                if (m_stack.size() == 0) begin
                    m_fault = 1; m_code = 2'b10; m_valid = 0;
                end else begin
                    m_pc = m_stack.pop_back();
                    m_insn = w; m_valid = 1;
                end
            end else begin
                m_pc = (m_pc + 1) % 65536;
                m_insn = w; m_valid = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        en = 1; br = 0; tgt = '0;
        rst = 1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset;
        rst = 1; en = 1; br = 0; tgt = '0;
        rom_clear(0, 65535);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_addr, o_valid, o_insn, o_fault, o_code} !== 48'h0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0",
                     {o_addr, o_valid, o_insn, o_fault, o_code});
        end
        @(negedge clk);
        rst = 0;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_addr !== 16'd0) begin
            errors++;
            $display("FAIL boot_bubble valid=%b addr=%h exp 0/0",
                     o_valid, o_addr);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            snap();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL nop_stream k=%0d got=%h exp=%h", k, got, exp);
            end
            checks++;
            if (o_addr !== 16'(k) || o_insn[23:0] !== 24'(k - 1)
                || o_valid !== 1'b1) begin
                errors++;
                $display("FAIL nop_lag k=%0d addr=%h insn=%h",
                         k, o_addr, o_insn);
            end
        end
    endtask

    task automatic test_call_ret;
        int ea[7] = '{1, 2, 3, 222, 223, 4, 5};
        int ed[7] = '{0, 0, 0, 1, 1, 0, 0};
        rom[3]   = {OP_CALL, 8'd222, 16'h0};
        rom[222] = {OP_ADD, 24'h123456};
        rom[223] = {OP_RET, 24'h0};
        do_reset();
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
            snap();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL call_ret_model k=%0d got=%h exp=%h",
                         k, got, exp);
            end
            checks++;
            if (o_addr !== 16'(ea[k]) || o_valid !== 1'b1
                || int'(dut.u_stack.ptr_q) != ed[k]) begin
                errors++;
                $display("FAIL call_ret_seq k=%0d addr=%0d depth=%0d exp %0d/%0d",
                         k, o_addr, dut.u_stack.ptr_q, ea[k], ed[k]);
            end
        end
        rom_clear(0, 255);
    endtask

    task automatic test_overflow;
        for (int i = 0; i <= 8; i++) rom[i] = {OP_CALL, 8'(i + 1), 16'h0};
        do_reset();
        tick();
        for (int k = 1; k <= 9; k++) begin
            tick();
            snap();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ovf_model k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        checks++;
        if ({o_fault, o_code, o_valid, o_addr} !== {1'b1, 2'b01, 1'b0, 16'd8}) begin
            errors++;
            $display("FAIL ovf_fault got f=%b c=%b v=%b a=%h exp 1/01/0/0008",
                     o_fault, o_code, o_valid, o_addr);
        end
        for (int k = 0; k < 3; k++) begin
            en = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            tgt = 16'h0040;
            tick();
            snap();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ovf_frozen k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        do_reset();
        checks++;
        if (o_addr !== 16'd0 || o_fault !== 1'b0 || o_code !== 2'b00
            || dut.u_stack.ptr_q !== '0) begin
            errors++;
            $display("FAIL ovf_reset addr=%h fault=%b code=%b exp 0/0/00",
                     o_addr, o_fault, o_code);
        end
        rom_clear(0, 8);
    endtask

    task automatic test_underflow;
        rom[0] = {OP_RET, 24'h0};
        do_reset();
        tick();
        tick();
        checks++;
        if ({o_fault, o_code, o_valid, o_addr} !== {1'b1, 2'b10, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL udf_fault got f=%b c=%b v=%b a=%h exp 1/10/0/0000",
                     o_fault, o_code, o_valid, o_addr);
        end
        rom_clear(0, 0);
    endtask

    task automatic test_branch;
        rom[2] = {OP_CALL, 8'h77, 16'h0};
        do_reset();
        repeat (3) tick();
        br = 1; tgt = 16'h0040;
        tick();
        br = 0;
        checks++;
        if (o_addr !== 16'h0040 || o_valid !== 1'b0
            || dut.u_stack.ptr_q !== '0) begin
            errors++;
            $display("FAIL branch_squash addr=%h valid=%b depth=%0d exp 0040/0/0",
                     o_addr, o_valid, dut.u_stack.ptr_q);
        end
        tick();
        snap();
        checks++;
        if (got !== exp || o_addr !== 16'h0041 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL branch_resume got=%h exp=%h", got, exp);
        end
        rom_clear(2, 2);
    endtask

    task automatic test_stall_wrap;
        logic [44:0] held;
        do_reset();
        repeat (6) tick();
        held = {o_addr, o_valid, o_insn};
        en = 0;
        for (int k = 0; k < 3; k++) begin
            br = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({o_addr, o_valid, o_insn} !== held || o_addr !== 16'd5) begin
                errors++;
                $display("FAIL stall_hold k=%0d got=%h exp=%h",
                         k, {o_addr, o_valid, o_insn}, held);
            end
        end
        en = 1; br = 1; tgt = 16'hFFFF;
        tick();
        br = 0;
        tick();
        snap();
        checks++;
        if (got !== exp || o_addr !== 16'h0000 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_async_reset;
        rom[2] = {OP_CALL, 8'h30, 16'h0};
        do_reset();
        repeat (4) tick();
        rst = 1;
        #2;
        checks++;
        if (o_addr !== 16'd0 || o_valid !== 1'b0
            || dut.u_stack.ptr_q !== '0) begin
            errors++;
            $display("FAIL async_reset addr=%h valid=%b depth=%0d exp 0/0/0",
                     o_addr, o_valid, dut.u_stack.ptr_q);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
        rom_clear(2, 2);
    endtask

    task automatic test_random;
        int r;
        for (int i = 0; i < 64; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)
                rom[i] = {(r < 3) ? OP_NOP : OP_ADD, 24'($urandom)};
            else if (r < 8)
                rom[i] = {OP_CALL, 8'($urandom_range(0, 63)), 16'($urandom)};
            else
                rom[i] = {OP_RET, 24'($urandom)};
        end
        do_reset();
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 4) != 0);
            br = ($urandom_range(0, 9) == 0);
            tgt = 16'($urandom_range(0, 63));
            tick();
            snap();
            checks++;
            if (got !== exp || int'(dut.u_stack.ptr_q) != m_stack.size()) begin
                errors++;
                $display("FAIL random k=%0d got=%h exp=%h depth=%0d exp=%0d",
                         k, got, exp, dut.u_stack.ptr_q, m_stack.size());
            end
            if (m_fault && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_branch();
        test_stall_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
